demux_frame_sequencer: RTL and testbench

- Upstream driver for the 1:8 demultiplexer, which has data input a, selects s1/s2/s3 (s1 = MSB) and out[7:0].
- Accepts a serial stream of data bits over a valid/ready handshake.
- Routes one bit per enabled channel, in ascending channel order 0..7. For each bit it drives a and the selects, holds them for a fixed number of cycles, then advances.
- Signals frame completion once the last enabled channel has been served.

---
 rtl/demux_frame_sequencer.sv | 141 ++++++++++++++
 tb/tb_demux_frame_sequencer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/demux_frame_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : demux_frame_sequencer                                           |
// | Brief    : Feeds a 1:8 demux one serial bit per enabled channel, in order. |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module demux_frame_sequencer #(
  parameter int HOLD_CYCLES  = 2,
  parameter bit AUTO_RESTART = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] chan_mask,
  input  logic       in_valid,
  input  logic       in_bit,
  output logic       in_ready,
  output logic       a,
  output logic       s1,
  output logic       s2,
  output logic       s3,
  output logic       busy,
  output logic       frame_done
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SEEK     = 3'd1,
    WAIT_BIT = 3'd2,
    HOLD     = 3'd3,
    DONE     = 3'd4
  } state_t;

  localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYCLES - 1);

  state_t     state, state_nx;
  logic [2:0] ptr, ptr_nx;
  logic [2:0] sel, sel_nx;
  logic [3:0] cnt, cnt_nx;
  logic [7:0] mask, mask_nx;
  logic       a_q, a_nx;
  logic       found;
  logic [2:0] found_idx;

  // Lowest enabled channel at or above the pointer; descending scan keeps the lowest.
  always_comb begin
    found     = 1'b0;
    found_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (mask[i] && (3'(i) >= ptr)) begin
        found     = 1'b1;
        found_idx = 3'(i);
      end
    end
  end

  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    sel_nx   = sel;
    cnt_nx   = cnt;
    mask_nx  = mask;
    a_nx     = a_q;
    case (state)
      IDLE: begin
        if (start) begin
          mask_nx  = chan_mask;
          ptr_nx   = 3'd0;
          state_nx = SEEK;
        end
      end
      SEEK: begin
        // Selects move only here, while a is already 0.
        if (found) begin
          ptr_nx   = found_idx;
          sel_nx   = found_idx;
          state_nx = WAIT_BIT;
        end else begin
          state_nx = DONE;
        end
      end
      WAIT_BIT: begin
        if (in_valid) begin
          a_nx     = in_bit;
          cnt_nx   = HOLD_LOAD;
          state_nx = HOLD;
        end
      end
      HOLD: begin
        if (cnt == 4'd0) begin
          a_nx = 1'b0;
          if (ptr == 3'd7) begin
            state_nx = DONE;
          end else begin
            ptr_nx   = ptr + 3'd1;
            state_nx = SEEK;
          end
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      DONE: begin
        if (AUTO_RESTART) begin
          ptr_nx   = 3'd0;
          state_nx = SEEK;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= 3'd0;
      sel   <= 3'd0;
      cnt   <= 4'd0;
      mask  <= 8'd0;
      a_q   <= 1'b0;
    end else begin
      state <= state_nx;
      ptr   <= ptr_nx;
      sel   <= sel_nx;
      cnt   <= cnt_nx;
      mask  <= mask_nx;
      a_q   <= a_nx;
    end
  end

  assign in_ready   = (state == WAIT_BIT);
  assign busy       = (state != IDLE);
  assign frame_done = (state == DONE);
  assign a          = a_q;
  assign s1         = sel[2];
  assign s2         = sel[1];
  assign s3         = sel[0];

endmodule
`default_nettype wire

// File: tb/tb_demux_frame_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_demux_frame_sequencer                                        |
// | Brief    : Randomized frame bench for demux_frame_sequencer.               |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_demux_frame_sequencer;

  localparam int H0 = 2;
  localparam int H1 = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       start0, in_valid0, in_bit0;
  logic [7:0] chan_mask0;
  logic       in_ready0, a0, s1_0, s2_0, s3_0, busy0, frame_done0;
  logic       start1, in_valid1, in_bit1;
  logic [7:0] chan_mask1;
  logic       in_ready1, a1, s1_1, s2_1, s3_1, busy1, frame_done1;

  logic [6:0] obs0;
  logic [7:0] dout0;
  int         n_cmp = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  demux_frame_sequencer #(.HOLD_CYCLES(H0), .AUTO_RESTART(1'b0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .chan_mask(chan_mask0),
    .in_valid(in_valid0), .in_bit(in_bit0), .in_ready(in_ready0), .a(a0),
    .s1(s1_0), .s2(s2_0), .s3(s3_0), .busy(busy0), .frame_done(frame_done0)
  );

  demux_frame_sequencer #(.HOLD_CYCLES(H1), .AUTO_RESTART(1'b1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .chan_mask(chan_mask1),
    .in_valid(in_valid1), .in_bit(in_bit1), .in_ready(in_ready1), .a(a1),
    .s1(s1_1), .s2(s2_1), .s3(s3_1), .busy(busy1), .frame_done(frame_done1)
  );

  // Observed tuple {in_ready, a, sel[2:0], busy, frame_done} plus an ideal 1:8 demux.
  always_comb begin
    obs0 = {in_ready0, a0, s1_0, s2_0, s3_0, busy0, frame_done0};
    dout0 = 8'd0;
    dout0[{s1_0, s2_0, s3_0}] = a0;
  end

  // Drives one frame on dut0 and checks every cycle against the expected schedule.
  task automatic run_frame(input logic [7:0] m, input logic [7:0] bits, input int stall_ch,
                           input int stall_len, input int abort_ch, input bit mid_start);
    int         chans[$];
    int         ch;
    logic       b;
    logic [2:0] cs;
    chans = {};
    for (int i = 0; i < 8; i++) if (m[i]) chans.push_back(i);
    start0 = 1'b1; chan_mask0 = m;
    @(negedge clk);
    start0 = 1'b0; chan_mask0 = 8'($urandom);
    n_cmp++;
    if (obs0[6] !== 1'b0 || obs0[5] !== 1'b0 || obs0[1:0] !== 2'b10) begin
      n_err++; $display("FAIL seek_entry: got %b want ir=0 a=0 busy=1 fd=0", obs0);
    end
    foreach (chans[k]) begin
      ch = chans[k]; cs = 3'(ch);
      in_valid0 = 1'($urandom); in_bit0 = 1'($urandom);
      @(negedge clk);
      n_cmp++;
      if (obs0 !== {1'b1, 1'b0, cs, 2'b10} || dout0 !== 8'd0) begin
        n_err++; $display("FAIL wait_ch%0d: got %b dout=%h want %b dout=00", ch, obs0, dout0, {1'b1, 1'b0, cs, 2'b10});
      end
      if (ch == stall_ch) begin
        in_valid0 = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          if (mid_start && s == 0) begin start0 = 1'b1; chan_mask0 = 8'($urandom); end
          @(negedge clk);
          start0 = 1'b0;
          n_cmp++;
          if (obs0 !== {1'b1, 1'b0, cs, 2'b10}) begin
            n_err++; $display("FAIL stall_ch%0d_%0d: got %b want %b", ch, s, obs0, {1'b1, 1'b0, cs, 2'b10});
          end
        end
      end
      b = bits[ch];
      in_valid0 = 1'b1; in_bit0 = b;
      @(negedge clk);
      for (int h = 0; h < H0; h++) begin
        n_cmp++;
        if (obs0 !== {1'b0, b, cs, 2'b10} || dout0 !== (8'(b) << ch)) begin
          n_err++; $display("FAIL hold_ch%0d_%0d: got %b dout=%h want %b dout=%h", ch, h, obs0, dout0, {1'b0, b, cs, 2'b10}, 8'(b) << ch);
        end
        in_valid0 = 1'($urandom); in_bit0 = 1'($urandom);
        if (ch == abort_ch && h == 0) begin
          rst = 1'b1;
          @(negedge clk);
          rst = 1'b0; in_valid0 = 1'b0;
          n_cmp++;
          if (obs0 !== 7'd0) begin
            n_err++; $display("FAIL abort_ch%0d: got %b want 0000000", ch, obs0);
          end
          @(negedge clk);
          n_cmp++;
          if (obs0 !== 7'd0) begin
            n_err++; $display("FAIL abort_idle: got %b want 0000000", obs0);
          end
          return;
        end
        @(negedge clk);
      end
      n_cmp++;
      if (a0 !== 1'b0 || in_ready0 !== 1'b0) begin
        n_err++; $display("FAIL release_ch%0d: got a=%b ir=%b want 0/0", ch, a0, in_ready0);
      end
    end
    if (chans.size() == 0 || chans[chans.size()-1] != 7) begin
      n_cmp++;
      if (frame_done0 !== 1'b0 || busy0 !== 1'b1) begin
        n_err++; $display("FAIL final_seek: got fd=%b busy=%b want 0/1", frame_done0, busy0);
      end
      @(negedge clk);
    end
    n_cmp++;
    if (frame_done0 !== 1'b1 || busy0 !== 1'b1 || in_ready0 !== 1'b0 || a0 !== 1'b0) begin
      n_err++; $display("FAIL done_pulse: got %b want fd=1 busy=1 ir=0 a=0", obs0);
    end
    in_valid0 = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (frame_done0 !== 1'b0 || busy0 !== 1'b0 || in_ready0 !== 1'b0 || a0 !== 1'b0) begin
      n_err++; $display("FAIL back_idle: got %b want all low (sel any)", obs0);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0; in_valid0 = 1'b1; in_bit0 = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++;
      if (obs0 !== 7'd0 || frame_done1 !== 1'b0 || busy1 !== 1'b0 || in_ready1 !== 1'b0) begin
        n_err++; $display("FAIL reset_c%0d: got %b dut1 busy=%b want 0000000", c, obs0, busy1);
      end
    end
    in_valid0 = 1'b0;
  endtask

  task automatic test_full_mask();
    run_frame(8'hFF, 8'b0100_1101, -1, 0, -1, 1'b0);
  endtask

  task automatic test_sparse_mask();
    run_frame(8'b1000_0101, 8'hFF, -1, 0, -1, 1'b0);
  endtask

  task automatic test_empty_mask();
    run_frame(8'h00, 8'h00, -1, 0, -1, 1'b0);
  endtask

  task automatic test_stall_and_busy_start();
    run_frame(8'hFF, 8'($urandom), 3, 5, -1, 1'b1);
  endtask

  task automatic test_reset_mid_frame();
    run_frame(8'hFF, 8'($urandom), -1, 0, 4, 1'b0);
    run_frame(8'h10, 8'hFF, -1, 0, -1, 1'b0);
  endtask

  task automatic test_random_frames();
    for (int f = 0; f < 8; f++)
      run_frame(8'($urandom), 8'($urandom), int'($urandom_range(0, 7)), int'($urandom_range(0, 3)), -1, 1'($urandom));
  endtask

  // Period of a repeating frame: SEEK+WAIT+HOLD per channel, a trailing SEEK unless ch7 ends it, then DONE.
  task automatic test_back_to_back();
    logic [7:0] m;
    int         period, last, pulses, a_high;
    m = 8'b0000_0101; period = 0; last = 0; pulses = 0; a_high = 0;
    for (int i = 0; i < 8; i++) if (m[i]) begin period += 2 + H1; last = i; end
    period += (last == 7) ? 1 : 2;
    start1 = 1'b1; chan_mask1 = m; in_valid1 = 1'b1; in_bit1 = 1'b1;
    for (int c = 1; c <= 3 * period + 4; c++) begin
      @(negedge clk);
      start1 = 1'b0; chan_mask1 = 8'($urandom);
      if (c <= 3 * period && a1 === 1'b1) a_high++;
      if (frame_done1 === 1'b1) pulses++;
      n_cmp++;
      if (frame_done1 !== 1'((c % period) == 0) || busy1 !== 1'b1) begin
        n_err++; $display("FAIL autorestart_c%0d: got fd=%b busy=%b want fd=%b busy=1", c, frame_done1, busy1, (c % period) == 0);
      end
    end
    n_cmp++;
    if (pulses != 3 || a_high != 3 * 2 * H1) begin
      n_err++; $display("FAIL autorestart_totals: got pulses=%0d a_high=%0d want 3/%0d", pulses, a_high, 6 * H1);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; in_valid1 = 1'b0;
    n_cmp++;
    if (busy1 !== 1'b0 || frame_done1 !== 1'b0 || a1 !== 1'b0 || {s1_1, s2_1, s3_1} !== 3'd0) begin
      n_err++; $display("FAIL autorestart_reset: got busy=%b fd=%b a=%b sel=%b want 0", busy1, frame_done1, a1, {s1_1, s2_1, s3_1});
    end
  endtask

  initial begin
    rst = 1'b1;
    start0 = 1'b0; chan_mask0 = 8'h00; in_valid0 = 1'b0; in_bit0 = 1'b0;
    start1 = 1'b0; chan_mask1 = 8'h00; in_valid1 = 1'b0; in_bit1 = 1'b0;
    test_reset();
    test_full_mask();
    test_sparse_mask();
    test_empty_mask();
    test_stall_and_busy_start();
    test_reset_mid_frame();
    test_random_frames();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
